dmem_port_arbiter: RTL

Sequences and arbitrates the single 16-bit data-memory port between the MEM stage and the interrupt unit, which pushes PC/flags during interrupt entry. It splits 32-bit accesses into two 16-bit beats and assembles 32-bit read data. It also raises the pipeline stall while a MEM-stage access is outstanding. It sits between the EX/MEM register, the interrupt unit and the data memory, after the MEM-MEM forwarding muxes that drive the MEM-stage address and write data.

---
 rtl/dmem_port_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Shares the single 16-bit data-memory port between the MEM stage and the interrupt unit,
// splitting 32-bit accesses into two beats and assembling 32-bit read data.
module dmem_port_arbiter #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic              mem_wide_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [31:0]       mem_wdata_in,
  input  logic              int_req_in,
  input  logic              int_we_in,
  input  logic              int_wide_in,
  input  logic [ADDR_W-1:0] int_addr_in,
  input  logic [31:0]       int_wdata_in,
  output logic              mem_gnt_out,
  output logic              int_gnt_out,
  output logic              mem_done_out,
  output logic              int_done_out,
  output logic [31:0]       rdata_out,
  output logic              stall_out,
  output logic [ADDR_W-1:0] dm_addr_out,
  output logic              dm_we_out,
  output logic [15:0]       dm_wdata_out,
  input  logic [15:0]       dm_rdata_in
);

  // state   | meaning
  // IDLE    | port free, arbitrating (INT over MEM), latching request fields
  // BEAT_LO | low half on the port
  // BEAT_HI | high half on the port at addr+1; read data of low beat arrives
  // WAIT_RD | last read beat arrives
  // FIN     | done pulse to owner, assembled read data presented
  typedef enum logic [2:0] {IDLE, BEAT_LO, BEAT_HI, WAIT_RD, FIN} state_t;

  state_t              state;
  logic                owner_int;
  logic                lat_we;
  logic                lat_wide;
  logic [ADDR_W-1:0]   lat_addr;
  logic [31:0]         lat_wdata;
  logic [31:0]         rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner_int <= 1'b0;
      lat_we    <= 1'b0;
      lat_wide  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (int_req_in) begin
            owner_int <= 1'b1;
            lat_we    <= int_we_in;
            lat_wide  <= int_wide_in;
            lat_addr  <= int_addr_in;
            lat_wdata <= int_wdata_in;
            rdata_q   <= '0;
            state     <= BEAT_LO;
          end else if (mem_req_in) begin
            owner_int <= 1'b0;
            lat_we    <= mem_we_in;
            lat_wide  <= mem_wide_in;
            lat_addr  <= mem_addr_in;
            lat_wdata <= mem_wdata_in;
            rdata_q   <= '0;
            state     <= BEAT_LO;
          end
        end
        BEAT_LO: begin
          if (lat_wide)     state <= BEAT_HI;
          else if (!lat_we) state <= WAIT_RD;
          else              state <= FIN;
        end
        BEAT_HI: begin
          if (!lat_we) rdata_q[15:0] <= dm_rdata_in;
          state <= lat_we ? FIN : WAIT_RD;
        end
        WAIT_RD: begin
          if (lat_wide) rdata_q[31:16] <= dm_rdata_in;
          else          rdata_q        <= {16'h0000, dm_rdata_in};
          state <= FIN;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic in_beat;
  logic busy;

  assign in_beat = (state == BEAT_LO) || (state == BEAT_HI);
  assign busy    = (state != IDLE);

  // High beat wraps naturally at the top of the address space.
  assign dm_addr_out  = (state == BEAT_LO) ? lat_addr :
                        (state == BEAT_HI) ? lat_addr + ADDR_W'(1) : '0;
  assign dm_wdata_out = (state == BEAT_LO) ? lat_wdata[15:0] :
                        (state == BEAT_HI) ? lat_wdata[31:16] : 16'h0000;
  assign dm_we_out    = in_beat & lat_we;

  assign int_gnt_out  = busy & owner_int;
  assign mem_gnt_out  = busy & ~owner_int;
  assign int_done_out = (state == FIN) & owner_int;
  assign mem_done_out = (state == FIN) & ~owner_int;
  assign rdata_out    = (state == FIN) ? rdata_q : 32'h0;
  assign stall_out    = mem_req_in & ~mem_done_out;

endmodule
